mult_rr_sched: RTL and testbench

//  Round-robin scheduler that shares one pipelined signed multiplier (sign-magnitude, N+1 x M+1 bit,

---
 rtl/mult_rr_sched.sv | 170 +++++++++++++++++
 tb/tb_mult_rr_sched.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_rr_sched.sv
// Round-robin scheduler sharing one pipelined sign-magnitude multiplier
// between R requesters, with ID tags, a credit limit and a result FIFO.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req_valid/ready    per-requester handshake (ready is one-hot or zero)
//   req_a, req_b       packed per-requester operands
//   mul_*              issue strobe/operands to and result from multiplier
//   rsp_*              valid/ready response stream (id + result)
//   err                sticky strobe/tag misalignment flag
module mult_rr_sched #(
    parameter int N   = 16,
    parameter int M   = 16,
    parameter int R   = 4,
    parameter int IDW = 2,
    parameter int LAT = 16,
    parameter int FD  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [R-1:0]       req_valid,
    output logic [R-1:0]       req_ready,
    input  logic [R*(N+1)-1:0] req_a,
    input  logic [R*(M+1)-1:0] req_b,
    output logic               mul_data_rdy,
    output logic [N:0]         mul_mult1_signed,
    output logic [M:0]         mul_mult2_signed,
    input  logic               mul_res_rdy,
    input  logic [N+M+1:0]     mul_res_signed,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [N+M+1:0]     rsp_data,
    output logic               err
);

    localparam int DW = N + M + 2;
    localparam int PW = (FD > 1) ? $clog2(FD) : 1;
    localparam int CW = $clog2(FD + 1);

    // Arbitration / issue state
    logic [IDW-1:0]          ptr_q, ptr_d;
    logic                    blank_q, blank_d;
    logic                    iss_v_q, iss_v_d;
    logic [IDW-1:0]          iss_id_q, iss_id_d;
    logic [N:0]              op_a_q, op_a_d;
    logic [M:0]              op_b_q, op_b_d;

    // Tag pipe: stage LAT-1 is the head
    logic [LAT-1:0]          tag_v_q, tag_v_d;
    logic [LAT-1:0][IDW-1:0] tag_id_q, tag_id_d;

    // Credits and FIFO
    logic [CW-1:0]           occ_q, occ_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic                    err_q, err_d;
    logic [IDW+DW-1:0]       mem_q [FD];

    logic                    found;
    logic [IDW-1:0]          gnt_id;
    logic                    grant;
    logic                    head_v;
    logic                    push;
    logic                    pop;
    logic                    drop;
    logic [IDW+DW-1:0]       head_word;

    // First valid requester at or after the pointer, wrapping mod R
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        for (int k = 0; k < R; k++) begin
            if (!found && req_valid[(int'(ptr_q) + k) % R]) begin
                found  = 1'b1;
                gnt_id = IDW'((int'(ptr_q) + k) % R);
            end
        end
    end

    // blank_q holds off grants in the first cycle after reset
    assign grant     = found && (occ_q < CW'(FD)) && !blank_q;
    assign req_ready = grant ? (R'(1) << gnt_id) : '0;

    assign head_v    = tag_v_q[LAT-1];
    assign push      = mul_res_rdy && head_v;
    assign drop      = head_v && !mul_res_rdy;
    assign rsp_valid = (cnt_q != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign head_word = mem_q[rd_ptr_q];

    always_comb begin
        ptr_d    = ptr_q;
        blank_d  = 1'b0;
        iss_v_d  = grant;
        iss_id_d = iss_id_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        if (grant) begin
            ptr_d    = (gnt_id == IDW'(R - 1)) ? '0 : gnt_id + IDW'(1);
            iss_id_d = gnt_id;
            op_a_d   = req_a[gnt_id*(N+1) +: N+1];
            op_b_d   = req_b[gnt_id*(M+1) +: M+1];
        end

        // The tag enters alongside the registered issue strobe
        tag_v_d  = {tag_v_q[LAT-2:0], iss_v_q};
        tag_id_d = {tag_id_q[LAT-2:0], iss_id_q};

        // A tag lost to a missing strobe also returns its credit
        occ_d = occ_q + CW'(grant) - CW'(pop) - CW'(drop);
        cnt_d = cnt_q + CW'(push) - CW'(pop);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push)
            wr_ptr_d = (wr_ptr_q == PW'(FD - 1)) ? '0 : wr_ptr_q + PW'(1);
        if (pop)
            rd_ptr_d = (rd_ptr_q == PW'(FD - 1)) ? '0 : rd_ptr_q + PW'(1);

        err_d = err_q | (mul_res_rdy ^ head_v);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q    <= '0;
            blank_q  <= 1'b1;
            iss_v_q  <= 1'b0;
            iss_id_q <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            tag_v_q  <= '0;
            tag_id_q <= '0;
            occ_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            blank_q  <= blank_d;
            iss_v_q  <= iss_v_d;
            iss_id_q <= iss_id_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            tag_v_q  <= tag_v_d;
            tag_id_q <= tag_id_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset; reads are masked while empty
    always_ff @(posedge clk) begin
        if (push && !rst)
            mem_q[wr_ptr_q] <= {tag_id_q[LAT-1], mul_res_signed};
    end

    assign mul_data_rdy     = iss_v_q;
    assign mul_mult1_signed = op_a_q;
    assign mul_mult2_signed = op_b_q;
    assign rsp_id           = rsp_valid ? head_word[IDW+DW-1:DW] : '0;
    assign rsp_data         = rsp_valid ? head_word[DW-1:0] : '0;
    assign err              = err_q;

endmodule

// File: tb/tb_mult_rr_sched.sv
// Directed bench for mult_rr_sched with a behavioural
// sign-magnitude multiplier of fixed latency LAT.
module tb_mult_rr_sched;

    localparam int N   = 16;
    localparam int M   = 16;
    localparam int R   = 4;
    localparam int IDW = 2;
    localparam int LAT = 16;
    localparam int FD  = 8;
    localparam int DW  = N + M + 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [R-1:0]       req_valid;
    logic [R-1:0]       req_ready;
    logic [R*(N+1)-1:0] req_a;
    logic [R*(M+1)-1:0] req_b;
    logic               mul_data_rdy;
    logic [N:0]         mul_mult1_signed;
    logic [M:0]         mul_mult2_signed;
    logic               mul_res_rdy;
    logic [DW-1:0]      mul_res_signed;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [DW-1:0]      rsp_data;
    logic               err;
    logic               inject;

    int checks   = 0;
    int failures = 0;
    int gcnt;
    int rcnt;

    // Hand-computed results for a = +(i+1), b = +2
    logic [DW-1:0] exp_d [4] = '{34'd2, 34'd4, 34'd6, 34'd8};

    always #5 clk = ~clk;

    mult_rr_sched #(
        .N(N), .M(M), .R(R), .IDW(IDW), .LAT(LAT), .FD(FD)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_a            (req_a),
        .req_b            (req_b),
        .mul_data_rdy     (mul_data_rdy),
        .mul_mult1_signed (mul_mult1_signed),
        .mul_mult2_signed (mul_mult2_signed),
        .mul_res_rdy      (mul_res_rdy),
        .mul_res_signed   (mul_res_signed),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_id           (rsp_id),
        .rsp_data         (rsp_data),
        .err              (err)
    );

    // Multiplier model, reset together with the scheduler
    logic [LAT-1:0] mv;
    logic [DW-1:0]  md [LAT];
    logic [31:0]    pm;
    assign pm = 32'(mul_mult1_signed[N-1:0]) * 32'(mul_mult2_signed[M-1:0]);

    always @(posedge clk) begin
        if (rst) begin
            mv <= '0;
        end else begin
            mv    <= {mv[LAT-2:0], mul_data_rdy};
            md[0] <= {mul_mult1_signed[N] ^ mul_mult2_signed[M], 1'b0, pm};
            for (int k = 1; k < LAT; k++)
                md[k] <= md[k-1];
        end
    end

    assign mul_res_rdy    = mv[LAT-1] | inject;
    assign mul_res_signed = md[LAT-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        inject    = 1'b0;
        for (int i = 0; i < R; i++) begin
            req_a[i*(N+1) +: N+1] = 17'(i + 1);
            req_b[i*(M+1) +: M+1] = 17'd2;
        end
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Cycle after reset: all outputs zero
        chk("rst_req_ready", 64'(req_ready), 0);
        chk("rst_data_rdy", 64'(mul_data_rdy), 0);
        chk("rst_op_a", 64'(mul_mult1_signed), 0);
        chk("rst_op_b", 64'(mul_mult2_signed), 0);
        chk("rst_rsp_valid", 64'(rsp_valid), 0);
        chk("rst_rsp_id", 64'(rsp_id), 0);
        chk("rst_rsp_data", 64'(rsp_data), 0);
        chk("rst_err", 64'(err), 0);
        tick();

        // 1: single op, -3 * +5 from requester 2
        req_a[2*(N+1) +: N+1] = 17'h1_0003;
        req_b[2*(M+1) +: M+1] = 17'h0_0005;
        req_valid = 4'b0100;
        #1;
        chk("t1_ready", 64'(req_ready), 64'h4);
        tick();
        req_valid = '0;
        chk("t1_data_rdy", 64'(mul_data_rdy), 1);
        chk("t1_op_a", 64'(mul_mult1_signed), 64'h1_0003);
        chk("t1_op_b", 64'(mul_mult2_signed), 64'h0_0005);
        for (int k = 0; k < LAT; k++)
            tick();
        chk("t1_early", 64'(rsp_valid), 0);
        tick();
        chk("t1_valid", 64'(rsp_valid), 1);
        chk("t1_id", 64'(rsp_id), 2);
        chk("t1_data", 64'(rsp_data), 64'h2_0000_000F);
        tick();
        chk("t1_drained", 64'(rsp_valid), 0);
        req_a[2*(N+1) +: N+1] = 17'd3;
        req_b[2*(M+1) +: M+1] = 17'd2;

        // 2: all requesters, rsp_ready=1
        do_reset();
        gcnt = 0;
        rcnt = 0;
        for (int c = 0; c < 80; c++) begin
            req_valid = (gcnt < 12) ? 4'hF : 4'h0;
            #1;
            if (|req_ready) begin
                chk("t2_grant", 64'(req_ready), 64'(1 << (gcnt % 4)));
                gcnt++;
            end
            if (rsp_valid) begin
                chk("t2_id", 64'(rsp_id), 64'(rcnt % 4));
                chk("t2_data", 64'(rsp_data), 64'(exp_d[rcnt % 4]));
                rcnt++;
            end
            tick();
        end
        chk("t2_grants", 64'(gcnt), 12);
        chk("t2_rsps", 64'(rcnt), 12);

        // 3: credit limit with rsp_ready=0
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        gcnt = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (|req_ready)
                gcnt++;
            tick();
        end
        chk("t3_grants", 64'(gcnt), 8);
        chk("t3_blocked", 64'(req_ready), 0);
        for (int c = 0; c < 18; c++)
            tick();
        chk("t3_still_blocked", 64'(req_ready), 0);
        rsp_ready = 1'b1;
        #1;
        chk("t3_first_valid", 64'(rsp_valid), 1);
        chk("t3_first_id", 64'(rsp_id), 0);
        chk("t3_first_data", 64'(rsp_data), 64'(exp_d[0]));
        chk("t3_no_same_cycle", 64'(req_ready), 0);
        tick();
        chk("t3_resume", 64'(req_ready), 64'h1);
        req_valid = '0;
        chk("t3_id1", 64'(rsp_id), 1);
        for (int k = 2; k < 8; k++) begin
            tick();
            chk("t3_valid", 64'(rsp_valid), 1);
            chk("t3_id", 64'(rsp_id), 64'(k % 4));
            chk("t3_data", 64'(rsp_data), 64'(exp_d[k % 4]));
        end
        tick();
        chk("t3_empty", 64'(rsp_valid), 0);

        // 4: sparse requesters 1 and 3
        do_reset();
        gcnt = 0;
        rcnt = 0;
        for (int c = 0; c < 40; c++) begin
            req_valid = (gcnt < 6) ? 4'b1010 : 4'h0;
            #1;
            if (|req_ready) begin
                chk("t4_grant", 64'(req_ready),
                    (gcnt % 2 == 0) ? 64'h2 : 64'h8);
                chk("t4_no_idle", 64'(c), 64'(gcnt));
                gcnt++;
            end
            if (rsp_valid) begin
                chk("t4_id", 64'(rsp_id), (rcnt % 2 == 0) ? 64'd1 : 64'd3);
                rcnt++;
            end
            tick();
        end
        chk("t4_grants", 64'(gcnt), 6);
        chk("t4_rsps", 64'(rcnt), 6);

        // 5: reset with 5 ops in flight
        do_reset();
        req_valid = 4'hF;
        for (int c = 0; c < 5; c++)
            tick();
        req_valid = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 4'hF;
        #1;
        chk("t5_rsp_valid", 64'(rsp_valid), 0);
        chk("t5_ready", 64'(req_ready), 0);
        chk("t5_err", 64'(err), 0);
        tick();
        chk("t5_ptr0", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        for (int c = 0; c < 40 && !rsp_valid; c++)
            tick();
        chk("t5_done", 64'(rsp_valid), 1);
        chk("t5_id", 64'(rsp_id), 0);
        chk("t5_data", 64'(rsp_data), 64'(exp_d[0]));
        chk("t5_err_after", 64'(err), 0);
        for (int c = 0; c < 4; c++)
            tick();

        // 6: spurious result strobe
        chk("t6_pre_err", 64'(err), 0);
        inject = 1'b1;
        tick();
        inject = 1'b0;
        chk("t6_err", 64'(err), 1);
        chk("t6_no_push", 64'(rsp_valid), 0);
        for (int c = 0; c < 3; c++)
            tick();
        chk("t6_sticky", 64'(err), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t6_err_cleared", 64'(err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
